soc_bus_fabric: RTL and testbench

Parametrised successor to the single-cycle SoC address decoder and read mux. It sits between the MIPS data port and NSLV memory-mapped slaves (data memory, accelerators, GPIO banks). It decodes a page field of the address and runs a registered request/ready transaction per access. Slaves may insert wait states, and a timeout with a sticky error status covers unmapped or hung slaves.

---
 rtl/soc_bus_fabric.sv | 228 ++++++++++++++++++++++
 tb/tb_soc_bus_fabric.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: page-decoded request/ready bridge from the MIPS data port to
// NSLV memory-mapped slaves. Each access runs IDLE -> ACCESS -> RESP. Slaves may
// stretch ACCESS with wait states, and a timeout aborts unmapped or hung slaves.
// Responses (m_ready/m_err/m_rdata) are presented one cycle after RESP.
// Optional feature macro: BUSFAB_PERF_EN builds the perf_xfers/perf_waits
// saturating counters. Without it both ports are tied to zero.
module soc_bus_fabric #(
   parameter int                   NSLV      = 4,
   parameter int                   DW        = 32,
   parameter int                   AW        = 32,
   parameter int                   DEC_LO    = 8,
   parameter int                   PW        = 4,
   parameter logic [NSLV*PW-1:0]   SLV_PAGES = {4'h9, 4'h8, 4'h1, 4'h0},
   parameter int                   TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m_req,
   input  logic                 m_we,
   input  logic [AW-1:0]        m_addr,
   input  logic [DW-1:0]        m_wdata,
   output logic [DW-1:0]        m_rdata,
   output logic                 m_ready,
   output logic                 m_err,
   output logic [NSLV-1:0]      s_sel,
   output logic                 s_we,
   output logic [AW-1:0]        s_addr,
   output logic [DW-1:0]        s_wdata,
   input  logic [NSLV*DW-1:0]   s_rdata,
   input  logic [NSLV-1:0]      s_ready,
   output logic                 err_sticky,
   output logic [15:0]          perf_xfers,
   output logic [15:0]          perf_waits
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

   state_t            state_q, state_d;
   logic [NSLV-1:0]   sel_q, sel_d;
   logic              swe_q, swe_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [7:0]        wait_q, wait_d;
   logic              resp_err_q, resp_err_d;
   logic [DW-1:0]     resp_data_q, resp_data_d;
   logic              sticky_q, sticky_d;
   logic              mready_q;
   logic              merr_q;
   logic [DW-1:0]     mrdata_q;

   logic [PW-1:0]     page_s;
   logic [NSLV-1:0]   match_s;
   logic [NSLV-1:0]   onehot_s;
   logic              hit_s;
   logic              rdy_s;
   logic [DW-1:0]     rdata_sel_s;

   assign page_s = m_addr[DEC_LO +: PW];

   // Page decode; isolating the lowest set match bit makes the lowest index win.
   always_comb begin
      match_s = '0;
      for (int i = 0; i < NSLV; i++) begin
         match_s[i] = (page_s == SLV_PAGES[i*PW +: PW]);
      end
      onehot_s = match_s & (~match_s + NSLV'(1));
      hit_s    = |match_s;
   end

   // Ready and read data of the selected slave only; other slaves are masked off.
   always_comb begin
      rdy_s       = |(s_ready & sel_q);
      rdata_sel_s = '0;
      for (int i = 0; i < NSLV; i++) begin
         rdata_sel_s = rdata_sel_s | ({DW{sel_q[i]}} & s_rdata[i*DW +: DW]);
      end
   end

   // Next-state and latched transaction fields.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      swe_d       = swe_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wait_d      = wait_q;
      resp_err_d  = resp_err_q;
      resp_data_d = resp_data_q;
      sticky_d    = sticky_q;
      case (state_q)
         ST_IDLE: begin
            if (m_req) begin
               addr_d  = m_addr;
               wdata_d = m_wdata;
               if (hit_s) begin
                  sel_d   = onehot_s;
                  swe_d   = m_we;
                  wait_d  = 8'd0;
                  state_d = ST_ACCESS;
               end else begin
                  resp_err_d  = 1'b1;
                  resp_data_d = '0;
                  sticky_d    = 1'b1;
                  state_d     = ST_RESP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (rdy_s) begin
               resp_data_d = rdata_sel_s;
               resp_err_d  = 1'b0;
               sel_d       = '0;
               swe_d       = 1'b0;
               state_d     = ST_RESP;
            end else if ((wait_q + 8'd1) == TO_LIM) begin
               wait_d      = wait_q + 8'd1;
               resp_data_d = '0;
               resp_err_d  = 1'b1;
               sticky_d    = 1'b1;
               sel_d       = '0;
               swe_d       = 1'b0;
               state_d     = ST_RESP;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            sel_d   = '0;
            swe_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and transaction registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         swe_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wait_q      <= 8'd0;
         resp_err_q  <= 1'b0;
         resp_data_q <= '0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         swe_q       <= swe_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wait_q      <= wait_d;
         resp_err_q  <= resp_err_d;
         resp_data_q <= resp_data_d;
         sticky_q    <= sticky_d;
      end
   end

   // Master response registers: loaded from the RESP cycle, pulse for one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mready_q <= 1'b0;
         merr_q   <= 1'b0;
         mrdata_q <= '0;
      end else begin
         mready_q <= (state_q == ST_RESP);
         if (state_q == ST_RESP) begin
            merr_q   <= resp_err_q;
            mrdata_q <= resp_data_q;
         end else begin
            merr_q   <= 1'b0;
            mrdata_q <= mrdata_q;
         end
      end
   end

`ifdef BUSFAB_PERF_EN
   logic [15:0] xfers_q;
   logic [15:0] waits_q;

   // Saturating counters of completions and ACCESS wait cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xfers_q <= 16'h0000;
         waits_q <= 16'h0000;
      end else begin
         if ((state_q == ST_RESP) && (xfers_q != 16'hFFFF)) begin
            xfers_q <= xfers_q + 16'd1;
         end else begin
            xfers_q <= xfers_q;
         end
         if ((state_q == ST_ACCESS) && !rdy_s && (waits_q != 16'hFFFF)) begin
            waits_q <= waits_q + 16'd1;
         end else begin
            waits_q <= waits_q;
         end
      end
   end

   assign perf_xfers = xfers_q;
   assign perf_waits = waits_q;
`else
   assign perf_xfers = 16'h0000;
   assign perf_waits = 16'h0000;
`endif

   assign s_sel      = sel_q;
   assign s_we       = swe_q;
   assign s_addr     = addr_q;
   assign s_wdata    = wdata_q;
   assign m_ready    = mready_q;
   assign m_err      = merr_q;
   assign m_rdata    = mrdata_q;
   assign err_sticky = sticky_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Self-checking bench for soc_bus_fabric: per-scenario tasks, expected responses
// queued at request time and popped when m_ready pulses.
module tb_soc_bus_fabric;

`ifdef BUSFAB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          m_req, m_we;
   logic [31:0]   m_addr, m_wdata, m_rdata;
   logic          m_ready, m_err;
   logic [3:0]    s_sel;
   logic          s_we;
   logic [31:0]   s_addr, s_wdata;
   logic [127:0]  s_rdata;
   logic [3:0]    s_ready;
   logic          err_sticky;
   logic [15:0]   perf_xfers, perf_waits;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } resp_t;

   resp_t exp_q[$];
   resp_t e;
   int    vec_cnt = 0;
   int    miss_cnt = 0;
   int    exp_xfers = 0;
   int    exp_waits = 0;

   soc_bus_fabric dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
      .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ready(s_ready),
      .err_sticky(err_sticky), .perf_xfers(perf_xfers), .perf_waits(perf_waits)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until m_ready is seen; lat = edges waited, -1 if the budget expires.
   task automatic wait_ready(input int budget, output int lat);
      lat = -1;
      for (int c = 1; c <= budget; c++) begin
         step();
         if (m_ready === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0; m_req = 1'b0; s_ready = 4'b0000;
      step(); step();
      rst = 1'b1;
      exp_xfers = 0; exp_waits = 0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      s_ready = 4'b0000; s_rdata = '0;
      step(); step();
      vec_cnt++;
      if ({m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata, err_sticky, perf_xfers, perf_waits} !== '0) begin
         miss_cnt++;
         $display("FAIL reset_outputs: got rdata=%h rdy=%b err=%b sel=%b we=%b addr=%h wd=%h stk=%b px=%h pw=%h, required all zero",
                  m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata, err_sticky, perf_xfers, perf_waits);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_read();
      int lat;
      s_rdata[31:0] = 32'hDEADBEEF; s_ready = 4'b0001;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0004;
      exp_q.push_back('{1'b0, 32'hDEADBEEF});
      step();
      m_req = 1'b0;
      vec_cnt++;
      if (s_sel !== 4'b0001 || s_we !== 1'b0 || s_addr !== 32'h4) begin
         miss_cnt++;
         $display("FAIL read_access: got sel=%b we=%b addr=%h, required 0001 0 00000004", s_sel, s_we, s_addr);
      end
      wait_ready(10, lat);
      exp_xfers++;
      vec_cnt++;
      if (lat !== 2) begin
         miss_cnt++;
         $display("FAIL read_latency: got %0d, required 2", lat);
      end
      e = exp_q.pop_front();
      vec_cnt++;
      if ({m_err, m_rdata} !== e) begin
         miss_cnt++;
         $display("FAIL read_resp: got err=%b data=%h, required err=%b data=%h", m_err, m_rdata, e.err, e.data);
      end
      step();
      vec_cnt++;
      if (m_ready !== 1'b0) begin
         miss_cnt++;
         $display("FAIL read_pulse_width: got m_ready=%b, required 0", m_ready);
      end
   endtask

   task automatic test_write_wait();
      int lat;
      s_rdata[95:64] = 32'hCAFE0002; s_ready = 4'b0000;
      m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0808; m_wdata = 32'd5;
      exp_q.push_back('{1'b0, 32'hCAFE0002});
      step();
      m_req = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         vec_cnt++;
         if (s_sel !== 4'b0100 || s_we !== 1'b1 || s_wdata !== 32'd5 || s_addr !== 32'h808) begin
            miss_cnt++;
            $display("FAIL write_access_c%0d: got sel=%b we=%b wd=%h addr=%h, required 0100 1 5 808", c, s_sel, s_we, s_wdata, s_addr);
         end
         if (c == 4) s_ready = 4'b0100;
         else exp_waits++;
         step();
      end
      s_ready = 4'b0000;
      vec_cnt++;
      if (s_sel !== 4'b0000 || s_we !== 1'b0) begin
         miss_cnt++;
         $display("FAIL write_release: got sel=%b we=%b, required 0000 0", s_sel, s_we);
      end
      wait_ready(10, lat);
      exp_xfers++;
      vec_cnt++;
      if (lat + 4 !== 5) begin
         miss_cnt++;
         $display("FAIL write_latency: got %0d, required 5", lat + 4);
      end
      e = exp_q.pop_front();
      vec_cnt++;
      if ({m_err, m_rdata} !== e || err_sticky !== 1'b0) begin
         miss_cnt++;
         $display("FAIL write_resp: got err=%b data=%h stk=%b, required err=%b data=%h stk=0", m_err, m_rdata, err_sticky, e.err, e.data);
      end
      vec_cnt++;
      if (perf_waits !== 16'(PERF ? exp_waits : 0) || perf_xfers !== 16'(PERF ? exp_xfers : 0)) begin
         miss_cnt++;
         $display("FAIL write_perf: got waits=%0d xfers=%0d, required %0d %0d", perf_waits, perf_xfers,
                  PERF ? exp_waits : 0, PERF ? exp_xfers : 0);
      end
   endtask

   task automatic test_unmapped();
      int lat;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0F00;
      exp_q.push_back('{1'b1, 32'h0});
      step();
      m_req = 1'b0;
      vec_cnt++;
      if (s_sel !== 4'b0000 || err_sticky !== 1'b1 || m_ready !== 1'b0) begin
         miss_cnt++;
         $display("FAIL unmapped_resp_cycle: got sel=%b stk=%b rdy=%b, required 0000 1 0", s_sel, err_sticky, m_ready);
      end
      wait_ready(10, lat);
      exp_xfers++;
      vec_cnt++;
      if (lat !== 1) begin
         miss_cnt++;
         $display("FAIL unmapped_latency: got %0d, required 1", lat);
      end
      e = exp_q.pop_front();
      vec_cnt++;
      if ({m_err, m_rdata} !== e) begin
         miss_cnt++;
         $display("FAIL unmapped_resp: got err=%b data=%h, required err=%b data=%h", m_err, m_rdata, e.err, e.data);
      end
   endtask

   task automatic test_timeout();
      int lat;
      apply_reset();
      vec_cnt++;
      if (err_sticky !== 1'b0) begin
         miss_cnt++;
         $display("FAIL timeout_sticky_pre: got %b, required 0", err_sticky);
      end
      s_rdata[127:96] = 32'h1234_5678; s_rdata[63:32] = 32'h0000_1111;
      s_ready = 4'b0111;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0900;
      exp_q.push_back('{1'b1, 32'h0});
      step();
      m_req = 1'b0;
      vec_cnt++;
      if (s_sel !== 4'b1000) begin
         miss_cnt++;
         $display("FAIL timeout_sel: got %b, required 1000", s_sel);
      end
      wait_ready(40, lat);
      exp_waits += 15; exp_xfers++;
      vec_cnt++;
      if (lat !== 16) begin
         miss_cnt++;
         $display("FAIL timeout_latency: got %0d, required 16", lat);
      end
      e = exp_q.pop_front();
      vec_cnt++;
      if ({m_err, m_rdata} !== e || err_sticky !== 1'b1 || s_sel !== 4'b0000) begin
         miss_cnt++;
         $display("FAIL timeout_resp: got err=%b data=%h stk=%b sel=%b, required err=1 data=0 stk=1 sel=0000",
                  m_err, m_rdata, err_sticky, s_sel);
      end
      s_rdata[31:0] = 32'h0BAD_F00D; s_ready = 4'b0001;
      m_req = 1'b1; m_addr = 32'h0000_0010;
      exp_q.push_back('{1'b0, 32'h0BAD_F00D});
      step();
      m_req = 1'b0;
      wait_ready(10, lat);
      exp_xfers++;
      e = exp_q.pop_front();
      vec_cnt++;
      if (lat !== 2 || {m_err, m_rdata} !== e) begin
         miss_cnt++;
         $display("FAIL timeout_recover: got lat=%0d err=%b data=%h, required 2 %b %h", lat, m_err, m_rdata, e.err, e.data);
      end
      vec_cnt++;
      if (perf_waits !== 16'(PERF ? exp_waits : 0) || perf_xfers !== 16'(PERF ? exp_xfers : 0)) begin
         miss_cnt++;
         $display("FAIL timeout_perf: got waits=%0d xfers=%0d, required %0d %0d", perf_waits, perf_xfers,
                  PERF ? exp_waits : 0, PERF ? exp_xfers : 0);
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      int seen;
      s_ready = 4'b0000;
      m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0104; m_wdata = 32'hA5A5_0001;
      step();
      m_req = 1'b0;
      step();
      #2 rst = 1'b0;
      #1;
      vec_cnt++;
      if ({m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata, err_sticky, perf_xfers, perf_waits} !== '0) begin
         miss_cnt++;
         $display("FAIL abort_async_clear: got rdata=%h rdy=%b sel=%b we=%b addr=%h wd=%h stk=%b px=%h pw=%h, required all zero",
                  m_rdata, m_ready, s_sel, s_we, s_addr, s_wdata, err_sticky, perf_xfers, perf_waits);
      end
      s_ready = 4'b1111;
      step(); step();
      rst = 1'b1;
      exp_xfers = 0; exp_waits = 0;
      s_ready = 4'b0000;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (m_ready !== 1'b0) seen++;
      end
      vec_cnt++;
      if (seen !== 0) begin
         miss_cnt++;
         $display("FAIL abort_no_ready: got %0d pulses, required 0", seen);
      end
      s_rdata[31:0] = 32'h7777_0000; s_ready = 4'b0001;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0020;
      exp_q.push_back('{1'b0, 32'h7777_0000});
      step();
      m_req = 1'b0;
      wait_ready(10, lat);
      exp_xfers++;
      e = exp_q.pop_front();
      vec_cnt++;
      if (lat !== 2 || {m_err, m_rdata} !== e) begin
         miss_cnt++;
         $display("FAIL abort_recover: got lat=%0d err=%b data=%h, required 2 %b %h", lat, m_err, m_rdata, e.err, e.data);
      end
   endtask

   task automatic test_back_to_back();
      int pulses[$];
      apply_reset();
      s_rdata[31:0] = 32'h0000_AAAA; s_rdata[63:32] = 32'h0000_BBBB;
      s_ready = 4'b0011;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0000;
      exp_q.push_back('{1'b0, 32'h0000_AAAA});
      exp_q.push_back('{1'b0, 32'h0000_BBBB});
      step();
      m_addr = 32'h0000_0100;
      for (int c = 1; c <= 6; c++) begin
         if (c == 3) begin
            vec_cnt++;
            if (s_sel !== 4'b0000) begin
               miss_cnt++;
               $display("FAIL b2b_resp_ignores_req: got sel=%b, required 0000", s_sel);
            end
         end
         if (c == 4) begin
            vec_cnt++;
            if (s_sel !== 4'b0010) begin
               miss_cnt++;
               $display("FAIL b2b_second_sel: got sel=%b, required 0010", s_sel);
            end
         end
         if (c == 5) m_req = 1'b0;
         if (m_ready === 1'b1) begin
            pulses.push_back(c - 1);
            exp_xfers++;
            if (exp_q.size() == 0) begin
               vec_cnt++; miss_cnt++;
               $display("FAIL b2b_unexpected_ready: at edge +%0d", c - 1);
            end else begin
               e = exp_q.pop_front();
               vec_cnt++;
               if ({m_err, m_rdata} !== e) begin
                  miss_cnt++;
                  $display("FAIL b2b_resp: got err=%b data=%h, required err=%b data=%h", m_err, m_rdata, e.err, e.data);
               end
            end
         end
         step();
      end
      vec_cnt++;
      if (pulses.size() !== 2 || pulses[0] !== 2 || pulses[1] !== 5) begin
         miss_cnt++;
         $display("FAIL b2b_timing: got %0d pulses, required 2 at edges +2 and +5", pulses.size());
      end
      vec_cnt++;
      if (perf_xfers !== 16'(PERF ? 2 : 0) || perf_waits !== 16'h0000) begin
         miss_cnt++;
         $display("FAIL b2b_perf: got xfers=%0d waits=%0d, required %0d 0", perf_xfers, perf_waits, PERF ? 2 : 0);
      end
      vec_cnt++;
      if (exp_q.size() !== 0) begin
         miss_cnt++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_wait();
      test_unmapped();
      test_timeout();
      test_reset_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
